key_conditioner: RTL and testbench

Multi-channel input conditioner for push-button and key lines. Per channel it provides a configurable synchroniser, a counter-based debouncer and an edge-to-pulse shaper with selectable edge mode and typematic auto-repeat. It sits between the raw pad inputs and the control FSMs, which consume single-cycle key pulses.

---
 rtl/key_conditioner.sv | 186 ++++++++++++++++++
 tb/tb_key_conditioner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner
// Multi-channel push-button conditioner. Each channel runs a pad-input
// synchroniser, a counter debouncer and a pulse shaper. The shaper can
// pulse on the rising edge, the falling edge or both edges of the debounced
// level, or on the rising edge with typematic auto-repeat. All outputs are
// registered, so inkey and mode have no combinational path to outkey.

module key_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_RATE     = 100
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] inkey,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] outkey,
    output logic [CHANNELS-1:0] level
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    // The counters act on the edge where they would reach their target, so
    // the comparison is against target-1 and the counter never holds the
    // target value itself.
    localparam logic [DB_W-1:0] DB_LAST       = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE        = DB_W'(1);
    localparam logic [RP_W-1:0] RP_DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RP_RATE_LAST  = RP_W'(REPEAT_RATE - 1);
    localparam logic [RP_W-1:0] RP_ONE        = RP_W'(1);

    localparam logic [1:0] MODE_RISE   = 2'b00;
    localparam logic [1:0] MODE_FALL   = 2'b01;
    localparam logic [1:0] MODE_BOTH   = 2'b10;
    localparam logic [1:0] MODE_REPEAT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_REPEAT = 2'b10
    } rpt_state_e;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_r;
    logic [CHANNELS-1:0]                  sync_s;

    // Synchroniser chain: stage 0 samples the raw pads, the last stage feeds the debouncers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], inkey};
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [DB_W-1:0] db_cnt_r;
        logic [DB_W-1:0] db_cnt_s;
        logic            level_r;
        logic            level_s;
        logic            level_prev_r;
        logic            rise_s;
        logic            fall_s;
        rpt_state_e      state_r;
        rpt_state_e      state_s;
        logic [RP_W-1:0] rp_cnt_r;
        logic [RP_W-1:0] rp_cnt_s;
        logic            pulse_s;
        logic            pulse_r;

        // Debouncer: count consecutive disagreeing cycles, toggle the level once the count is met.
        always_comb begin
            db_cnt_s = '0;
            level_s  = level_r;
            if (sync_s[g] != level_r) begin
                if (db_cnt_r == DB_LAST) begin
                    level_s  = ~level_r;
                    db_cnt_s = '0;
                end else begin
                    db_cnt_s = db_cnt_r + DB_ONE;
                end
            end else begin
                db_cnt_s = '0;
            end
        end

        assign rise_s = level_r & ~level_prev_r;
        assign fall_s = ~level_r & level_prev_r;

        // Pulse shaper and auto-repeat FSM; a falling level (seen on level_s) cancels repeat at once.
        always_comb begin
            state_s  = state_r;
            rp_cnt_s = rp_cnt_r;
            pulse_s  = 1'b0;
            case (mode)
                MODE_RISE: begin
                    pulse_s  = rise_s;
                    state_s  = ST_IDLE;
                    rp_cnt_s = '0;
                end
                MODE_FALL: begin
                    pulse_s  = fall_s;
                    state_s  = ST_IDLE;
                    rp_cnt_s = '0;
                end
                MODE_BOTH: begin
                    pulse_s  = rise_s | fall_s;
                    state_s  = ST_IDLE;
                    rp_cnt_s = '0;
                end
                MODE_REPEAT: begin
                    case (state_r)
                        ST_IDLE: begin
                            rp_cnt_s = '0;
                            if (rise_s) begin
                                pulse_s = 1'b1;
                                state_s = ST_DELAY;
                            end else begin
                                state_s = ST_IDLE;
                            end
                        end
                        ST_DELAY: begin
                            if (!level_s) begin
                                state_s  = ST_IDLE;
                                rp_cnt_s = '0;
                            end else if (rp_cnt_r == RP_DELAY_LAST) begin
                                pulse_s  = 1'b1;
                                state_s  = ST_REPEAT;
                                rp_cnt_s = '0;
                            end else begin
                                rp_cnt_s = rp_cnt_r + RP_ONE;
                            end
                        end
                        ST_REPEAT: begin
                            if (!level_s) begin
                                state_s  = ST_IDLE;
                                rp_cnt_s = '0;
                            end else if (rp_cnt_r == RP_RATE_LAST) begin
                                pulse_s  = 1'b1;
                                rp_cnt_s = '0;
                            end else begin
                                rp_cnt_s = rp_cnt_r + RP_ONE;
                            end
                        end
                        default: begin
                            state_s  = ST_IDLE;
                            rp_cnt_s = '0;
                        end
                    endcase
                end
                default: begin
                    state_s  = ST_IDLE;
                    rp_cnt_s = '0;
                end
            endcase
        end

        // Per-channel state: debounce counter, level history, repeat FSM and output pulse.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                db_cnt_r     <= '0;
                level_r      <= 1'b0;
                level_prev_r <= 1'b0;
                state_r      <= ST_IDLE;
                rp_cnt_r     <= '0;
                pulse_r      <= 1'b0;
            end else begin
                db_cnt_r     <= db_cnt_s;
                level_r      <= level_s;
                level_prev_r <= level_r;
                state_r      <= state_s;
                rp_cnt_r     <= rp_cnt_s;
                pulse_r      <= pulse_s;
            end
        end

        assign level[g]  = level_r;
        assign outkey[g] = pulse_r;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner (4 channels, 2 sync stages,
// debounce 4, repeat delay 20, repeat rate 5). Expected pulses are queued
// with their absolute edge number when stimulus is driven; every clock the
// queue entries due at that edge are popped and compared with outkey.
// A press driven just after edge c is first sampled at edge c+1, so the
// level moves at c+6 and the pulse appears at c+7.

module tb_key_conditioner;

    logic       clock;
    logic       reset;
    logic [3:0] inkey;
    logic [1:0] mode;
    logic [3:0] outkey;
    logic [3:0] level;

    key_conditioner #(
        .CHANNELS        (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (5)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .inkey  (inkey),
        .mode   (mode),
        .outkey (outkey),
        .level  (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         edge_no;
        logic [3:0] mask;
    } exp_t;

    typedef struct {
        logic [3:0] inkey;
        logic [1:0] mode;
        int         hold;
        logic [3:0] exp_level;
        logic [3:0] exp_pulse;
    } vec_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic expect_pulse(input int e, input logic [3:0] m);
        exp_t x;
        x.edge_no = e;
        x.mask    = m;
        exp_q.push_back(x);
    endtask

    // One clock: wait for the edge, let outputs settle, pop what is due and compare.
    task automatic step();
        logic [3:0] want;
        @(posedge clock);
        #1;
        want = 4'b0000;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].edge_no == cyc) begin
                want = want | exp_q[i].mask;
                exp_q.delete(i);
            end
        end
        check($sformatf("outkey@%0d", cyc), {28'b0, outkey}, {28'b0, want});
    endtask

    task automatic wait_to(input int e);
        while (cyc < e) step();
    endtask

    vec_t vt [11];
    int   c;
    int   p;
    int   r;

    initial begin
        vt[0]  = '{4'b0001, 2'b00, 10, 4'b0001, 4'b0001};  // rise mode, press ch0
        vt[1]  = '{4'b0000, 2'b00, 10, 4'b0000, 4'b0000};  // release: no pulse
        vt[2]  = '{4'b0100, 2'b10, 10, 4'b0100, 4'b0100};  // both edges, press ch2
        vt[3]  = '{4'b0000, 2'b10, 10, 4'b0000, 4'b0100};  // both edges, release ch2
        vt[4]  = '{4'b0100, 2'b01, 10, 4'b0100, 4'b0000};  // fall mode, press: silent
        vt[5]  = '{4'b0000, 2'b01, 10, 4'b0000, 4'b0100};  // fall mode, release pulses
        vt[6]  = '{4'b1001, 2'b00, 10, 4'b1001, 4'b1001};  // simultaneous ch0+ch3
        vt[7]  = '{4'b0000, 2'b00, 10, 4'b0000, 4'b0000};
        vt[8]  = '{4'b0110, 2'b10, 10, 4'b0110, 4'b0110};
        vt[9]  = '{4'b0010, 2'b01, 10, 4'b0010, 4'b0100};  // only ch2 falls
        vt[10] = '{4'b0000, 2'b01, 10, 4'b0000, 4'b0010};

        // Reset: asserted with all keys high, outputs must be low with no clock edge.
        reset = 1'b1;
        inkey = 4'hF;
        mode  = 2'b00;
        #1 reset = 1'b0;
        #1;
        check("reset outkey immediate", {28'b0, outkey}, 32'h0);
        check("reset level immediate", {28'b0, level}, 32'h0);
        repeat (3) step();
        check("reset level held", {28'b0, level}, 32'h0);
        inkey = 4'h0;
        reset = 1'b1;
        repeat (50) step();
        check("idle level after reset", {28'b0, level}, 32'h0);

        // Clean press on ch0: level rises exactly at c+6, single pulse at c+7.
        c = cyc;
        inkey = 4'b0001;
        expect_pulse(c + 7, 4'b0001);
        wait_to(c + 5);
        check("press level edge5", {28'b0, level}, 32'h0);
        step();
        check("press level edge6", {28'b0, level}, 32'h1);
        wait_to(c + 10);
        c = cyc;
        inkey = 4'b0000;
        wait_to(c + 5);
        check("release level edge5", {28'b0, level}, 32'h1);
        step();
        check("release level edge6", {28'b0, level}, 32'h0);
        wait_to(c + 10);

        // Table of single-step press/release vectors across the edge modes.
        for (int i = 0; i < 11; i++) begin
            c = cyc;
            inkey = vt[i].inkey;
            mode  = vt[i].mode;
            if (vt[i].exp_pulse != 4'b0000) expect_pulse(c + 7, vt[i].exp_pulse);
            wait_to(c + vt[i].hold);
            check($sformatf("vec%0d level", i), {28'b0, level}, {28'b0, vt[i].exp_level});
        end

        // Bounce on ch1: 2-cycle toggles never satisfy the debouncer; the final stable 1 does.
        mode = 2'b00;
        c = cyc;
        for (int k = 0; k < 6; k++) begin
            inkey[1] = (k % 2 == 0) ? 1'b1 : 1'b0;
            wait_to(c + 2 * (k + 1));
            check($sformatf("bounce level k%0d", k), {28'b0, level}, 32'h0);
        end
        c = cyc;
        inkey[1] = 1'b1;
        expect_pulse(c + 7, 4'b0010);
        wait_to(c + 12);
        check("bounce settled level", {28'b0, level}, 32'h2);
        inkey[1] = 1'b0;
        repeat (10) step();

        // 3-cycle glitch on ch2: one short of the threshold, no level change.
        c = cyc;
        inkey[2] = 1'b1;
        wait_to(c + 3);
        inkey[2] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("glitch3 level +%0d", k), {28'b0, level}, 32'h0);
        end

        // 4-cycle pulse on ch0: exactly meets the threshold, so it is accepted.
        c = cyc;
        inkey[0] = 1'b1;
        expect_pulse(c + 7, 4'b0001);
        wait_to(c + 4);
        inkey[0] = 1'b0;
        wait_to(c + 6);
        check("glitch4 level up", {28'b0, level}, 32'h1);
        wait_to(c + 10);
        check("glitch4 level down", {28'b0, level}, 32'h0);
        repeat (4) step();

        // Auto-repeat on ch3; level falls exactly on P+65, so that repeat is suppressed.
        mode = 2'b11;
        repeat (2) step();
        c = cyc;
        p = c + 7;
        inkey = 4'b1000;
        expect_pulse(p, 4'b1000);
        for (int k = 0; k < 9; k++) expect_pulse(p + 20 + 5 * k, 4'b1000);
        wait_to(p + 59);
        inkey = 4'b0000;
        wait_to(p + 64);
        check("repeat level before drop", {28'b0, level}, 32'h8);
        step();
        check("repeat level dropped", {28'b0, level}, 32'h0);
        wait_to(p + 75);

        // Leaving repeat mode mid-delay forces IDLE; re-entering with the key held stays silent.
        c = cyc;
        p = c + 7;
        inkey = 4'b1000;
        expect_pulse(p, 4'b1000);
        wait_to(p + 5);
        mode = 2'b00;
        wait_to(p + 30);
        mode = 2'b11;
        wait_to(p + 50);
        check("mode switch level held", {28'b0, level}, 32'h8);
        inkey = 4'b0000;
        repeat (10) step();

        // Async reset on a repeat-pulse cycle, then a fresh press sequence with the key held.
        c = cyc;
        p = c + 7;
        inkey = 4'b0001;
        expect_pulse(p, 4'b0001);
        expect_pulse(p + 20, 4'b0001);
        expect_pulse(p + 25, 4'b0001);
        wait_to(p + 25);
        #1 reset = 1'b0;
        #1;
        check("midrepeat reset outkey", {28'b0, outkey}, 32'h0);
        check("midrepeat reset level", {28'b0, level}, 32'h0);
        repeat (3) step();
        reset = 1'b1;
        r = cyc;
        expect_pulse(r + 7, 4'b0001);
        expect_pulse(r + 27, 4'b0001);
        expect_pulse(r + 32, 4'b0001);
        wait_to(r + 6);
        check("post reset level", {28'b0, level}, 32'h1);
        wait_to(r + 27);
        inkey = 4'b0000;
        wait_to(r + 40);
        check("final level", {28'b0, level}, 32'h0);

        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
